// File: rtl/led_ring_sequencer.sv
// LED ring pattern sequencer: SPIN / BLINK / FILL animations on five status LEDs,
// started and stopped over a valid/ready command handshake.
module led_ring_sequencer #(
  parameter int TICK_DIV    = 3000000,
  parameter int CNT_W       = 22,
  parameter int SPIN_LAPS   = 2,
  parameter int BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  output logic       busy,
  output logic       led_d1_top,
  output logic       led_d2_right,
  output logic       led_d3_bottom,
  output logic       led_d4_left,
  output logic       led_d5_middle
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SPIN  = 2'b01,
    BLINK = 2'b10,
    FILL  = 2'b11
  } state_t;

  localparam int SPIN_N  = 4 * SPIN_LAPS;
  localparam int BLINK_N = 2 * BLINK_COUNT;
  localparam int FILL_N  = 5;
  localparam int N_A     = (SPIN_N > BLINK_N) ? SPIN_N : BLINK_N;
  localparam int N_MAX   = (N_A > FILL_N) ? N_A : FILL_N;
  localparam int STEP_W  = $clog2(N_MAX);

  localparam logic [CNT_W-1:0]  CNT_TOP    = CNT_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] SPIN_LAST  = STEP_W'(SPIN_N - 1);
  localparam logic [STEP_W-1:0] BLINK_LAST = STEP_W'(BLINK_N - 1);
  localparam logic [STEP_W-1:0] FILL_LAST  = STEP_W'(FILL_N - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  // led bit order: {middle, left, bottom, right, top}
  logic [4:0]        r_led, w_led_nxt;

  logic w_busy, w_acc, w_stop, w_start, w_tick, w_last;

  function automatic logic [4:0] f_pat(
    input logic [1:0]        mode,
    input logic [STEP_W-1:0] step
  );
    logic [4:0] p;
    p = 5'b00000;
    case (mode)
      2'b01: begin
        case (step[1:0])
          2'd0:    p = 5'b10001;
          2'd1:    p = 5'b10010;
          2'd2:    p = 5'b10100;
          default: p = 5'b11000;
        endcase
      end
      2'b10: p = step[0] ? 5'b00000 : 5'b11111;
      2'b11: begin
        case (step)
          STEP_W'(0): p = 5'b00001;
          STEP_W'(1): p = 5'b00011;
          STEP_W'(2): p = 5'b00111;
          STEP_W'(3): p = 5'b01111;
          default:    p = 5'b11111;
        endcase
      end
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

  assign w_busy    = (r_state != IDLE);
  assign busy      = w_busy;
  assign cmd_ready = !w_busy || (cmd_mode == 2'b00);

  assign w_acc   = cmd_valid && cmd_ready;
  assign w_stop  = w_acc && (cmd_mode == 2'b00);
  assign w_start = w_acc && (cmd_mode != 2'b00);
  assign w_tick  = w_busy && (r_cnt == CNT_TOP);

  always_comb begin
    w_last = 1'b0;
    unique case (1'b1)
      (r_state == SPIN):  w_last = (r_step == SPIN_LAST);
      (r_state == BLINK): w_last = (r_step == BLINK_LAST);
      (r_state == FILL):  w_last = (r_step == FILL_LAST);
      default:            w_last = 1'b0;
    endcase
  end

  // STOP has priority over a coincident tick
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_led_nxt   = r_led;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_step_nxt  = '0;
      w_led_nxt   = 5'b00000;
    end else if (w_start) begin
      w_state_nxt = state_t'(cmd_mode);
      w_cnt_nxt   = '0;
      w_step_nxt  = '0;
      w_led_nxt   = f_pat(cmd_mode, '0);
    end else if (w_tick) begin
      w_cnt_nxt = '0;
      if (w_last) begin
        w_state_nxt = IDLE;
        w_step_nxt  = '0;
        w_led_nxt   = 5'b00000;
      end else begin
        w_step_nxt = r_step + 1'b1;
        w_led_nxt  = f_pat(r_state, r_step + 1'b1);
      end
    end else if (w_busy) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_led   <= 5'b00000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign led_d1_top    = r_led[0];
  assign led_d2_right  = r_led[1];
  assign led_d3_bottom = r_led[2];
  assign led_d4_left   = r_led[3];
  assign led_d5_middle = r_led[4];

endmodule

// File: tb/tb_led_ring_sequencer.sv
// Directed-vector bench for led_ring_sequencer with a fast step rate.
module tb_led_ring_sequencer;

  logic       clk;
  logic       nRst;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       busy;
  logic       l_top, l_right, l_bottom, l_left, l_mid;

  int n_chk;
  int n_err;

  led_ring_sequencer #(
    .TICK_DIV(4),
    .CNT_W(2),
    .SPIN_LAPS(2),
    .BLINK_COUNT(3)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .led_d1_top(l_top),
    .led_d2_right(l_right),
    .led_d3_bottom(l_bottom),
    .led_d4_left(l_left),
    .led_d5_middle(l_mid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] leds();
    return {l_mid, l_left, l_bottom, l_right, l_top};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    adv(1);
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    nRst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    #1;
    chk("rst_led", leds(), 5'b00000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", cmd_ready, 1'b1);
    adv(3);
    nRst = 1'b1;

    // 1: idle for 50 cycles
    for (int i = 0; i < 50; i++) begin
      adv(1);
      if (busy !== 1'b0 || leds() !== 5'b00000)
        chk("idle_quiet", {busy, leds()}, 6'b000000);
    end
    chk("idle_busy", busy, 1'b0);
    chk("idle_led", leds(), 5'b00000);
    chk("idle_rdy", cmd_ready, 1'b1);

    // 2: SPIN
    issue(2'b01);
    chk("spin_e0", leds(), 5'b10001);
    chk("spin_busy", busy, 1'b1);
    adv(3);
    chk("spin_e3", leds(), 5'b10001);
    adv(1);
    chk("spin_e4", leds(), 5'b10010);
    adv(4);
    chk("spin_e8", leds(), 5'b10100);
    adv(4);
    chk("spin_e12", leds(), 5'b11000);
    adv(4);
    chk("spin_e16", leds(), 5'b10001);
    adv(15);
    chk("spin_e31", leds(), 5'b11000);
    chk("spin_e31b", busy, 1'b1);
    adv(1);
    chk("spin_e32", leds(), 5'b00000);
    chk("spin_e32b", busy, 1'b0);

    // 3: BLINK
    issue(2'b10);
    chk("blk_e0", leds(), 5'b11111);
    adv(4);
    chk("blk_e4", leds(), 5'b00000);
    adv(4);
    chk("blk_e8", leds(), 5'b11111);
    adv(12);
    chk("blk_e20", leds(), 5'b00000);
    adv(3);
    chk("blk_e23b", busy, 1'b1);
    adv(1);
    chk("blk_e24b", busy, 1'b0);
    chk("blk_e24", leds(), 5'b00000);

    // 3: FILL
    issue(2'b11);
    chk("fil_e0", leds(), 5'b00001);
    adv(4);
    chk("fil_e4", leds(), 5'b00011);
    adv(4);
    chk("fil_e8", leds(), 5'b00111);
    adv(4);
    chk("fil_e12", leds(), 5'b01111);
    adv(4);
    chk("fil_e16", leds(), 5'b11111);
    adv(4);
    chk("fil_e20b", busy, 1'b0);
    chk("fil_e20", leds(), 5'b00000);

    // 4: BLINK held during SPIN
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    adv(1);
    cmd_mode = 2'b10;
    chk("b2b_e0", leds(), 5'b10001);
    chk("b2b_rdy0", cmd_ready, 1'b0);
    adv(4);
    chk("b2b_e4", leds(), 5'b10010);
    chk("b2b_rdy4", cmd_ready, 1'b0);
    adv(27);
    chk("b2b_e31", leds(), 5'b11000);
    chk("b2b_rdy31", cmd_ready, 1'b0);
    adv(1);
    chk("b2b_e32b", busy, 1'b0);
    chk("b2b_e32", leds(), 5'b00000);
    chk("b2b_rdy32", cmd_ready, 1'b1);
    adv(1);
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    chk("b2b_e33b", busy, 1'b1);
    chk("b2b_e33", leds(), 5'b11111);
    adv(4);
    chk("b2b_e37", leds(), 5'b00000);
    issue(2'b00);
    chk("b2b_stop", busy, 1'b0);

    // 5: STOP mid-step
    issue(2'b01);
    adv(5);
    chk("stm_pre", leds(), 5'b10010);
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    chk("stm_rdy", cmd_ready, 1'b1);
    adv(1);
    cmd_valid = 1'b0;
    chk("stm_led", leds(), 5'b00000);
    chk("stm_busy", busy, 1'b0);
    adv(5);
    chk("stm_hold", {busy, leds()}, 6'b000000);

    // 5: STOP on a tick edge
    issue(2'b01);
    adv(3);
    chk("stt_pre", leds(), 5'b10001);
    issue(2'b00);
    chk("stt_led", leds(), 5'b00000);
    chk("stt_busy", busy, 1'b0);

    // STOP in IDLE is a no-op
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    adv(2);
    cmd_valid = 1'b0;
    chk("sti_state", {busy, leds()}, 6'b000000);
    chk("sti_rdy", cmd_ready, 1'b1);

    // 6: async reset mid-FILL
    issue(2'b11);
    adv(9);
    chk("rmf_pre", leds(), 5'b00111);
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    #2;
    nRst = 1'b0;
    #1;
    chk("rmf_led", leds(), 5'b00000);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_rdy", cmd_ready, 1'b1);
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    adv(2);
    chk("rmf_held", {busy, leds()}, 6'b000000);
    nRst = 1'b1;
    adv(2);
    chk("rmf_idle", {busy, leds()}, 6'b000000);
    issue(2'b01);
    chk("rmf_s0", leds(), 5'b10001);
    adv(4);
    chk("rmf_s4", leds(), 5'b10010);
    adv(28);
    chk("rmf_done", {busy, leds()}, 6'b000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
